// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS sequencing control unit.
// Decodes the instruction register into datapath mux selects and walks each
// instruction through FETCH/DECODE/EXEC/MEM/WB, waiting on the memory
// handshakes, trapping on memory timeout or signed overflow, and counting
// retired instructions.
module multicycle_control_unit #(
  parameter int WORD_W      = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] instr,
  input  logic              of,
  input  logic              zero,
  input  logic              ihit,
  input  logic              dhit,
  output logic              iREN,
  output logic              irWEN,
  output logic              dREN,
  output logic              dWEN,
  output logic              regWEN,
  output logic              pcWEN,
  output logic [3:0]        aluOp,
  output logic [1:0]        portb_sel,
  output logic              porta_sel,
  output logic              immExt_sel,
  output logic [1:0]        regW_sel,
  output logic [1:0]        wMemReg_sel,
  output logic [1:0]        pc_sel,
  output logic              halt,
  output logic              err,
  output logic [CNT_W-1:0]  retire_cnt
);

  // Sequencer states
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALTED = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  // ALU operation encodings shared with the single-cycle datapath
  localparam logic [3:0] ALU_SLL  = 4'd0;
  localparam logic [3:0] ALU_SRL  = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // Wait counter only needs to reach MEM_TIMEOUT; it saturates so that the
  // no-timeout configuration never wraps.
  localparam int              WAIT_W    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  logic [2:0]        state_r;
  logic [2:0]        next_state_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              halt_r;
  logic              err_r;
  logic [CNT_W-1:0]  retire_cnt_r;

  logic [5:0] opcode_s;
  logic [5:0] funct_s;
  logic       unused_instr_s;

  // Decoded instruction class
  logic is_j_s, is_jal_s, is_jr_s, is_beq_s, is_bne_s;
  logic is_lw_s, is_sw_s, is_halt_s;
  logic alu_write_s;   // known instruction that writes the register file
  logic can_trap_s;    // signed add/sub that halts on overflow
  logic timeout_s;
  logic retire_s;

  logic [3:0] alu_op_s;
  logic [1:0] portb_sel_s;
  logic       porta_sel_s;
  logic       imm_ext_sel_s;
  logic [1:0] reg_w_sel_s;
  logic [1:0] w_mem_reg_sel_s;
  logic [1:0] pc_sel_s;

  logic i_ren_s, ir_wen_s, d_ren_s, d_wen_s, reg_wen_s, pc_wen_s;

  assign opcode_s       = instr[WORD_W-1 -: 6];
  assign funct_s        = instr[5:0];
  assign unused_instr_s = ^instr[WORD_W-7:6];

  // Instruction decode: mux selects and instruction class from the IR
  always_comb begin
    alu_op_s        = ALU_ADD;
    portb_sel_s     = 2'b00;
    porta_sel_s     = 1'b0;
    imm_ext_sel_s   = 1'b0;
    reg_w_sel_s     = 2'b00;
    w_mem_reg_sel_s = 2'b00;
    is_j_s          = 1'b0;
    is_jal_s        = 1'b0;
    is_jr_s         = 1'b0;
    is_beq_s        = 1'b0;
    is_bne_s        = 1'b0;
    is_lw_s         = 1'b0;
    is_sw_s         = 1'b0;
    is_halt_s       = 1'b0;
    alu_write_s     = 1'b0;
    can_trap_s      = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        reg_w_sel_s = 2'b00;
        case (funct_s)
          FN_SLL:  begin alu_op_s = ALU_SLL;  portb_sel_s = 2'b01; alu_write_s = 1'b1; end
          FN_SRL:  begin alu_op_s = ALU_SRL;  portb_sel_s = 2'b01; alu_write_s = 1'b1; end
          FN_JR:   begin is_jr_s = 1'b1; end
          FN_ADD:  begin alu_op_s = ALU_ADD;  alu_write_s = 1'b1; can_trap_s = 1'b1; end
          FN_ADDU: begin alu_op_s = ALU_ADD;  alu_write_s = 1'b1; end
          FN_SUB:  begin alu_op_s = ALU_SUB;  alu_write_s = 1'b1; can_trap_s = 1'b1; end
          FN_SUBU: begin alu_op_s = ALU_SUB;  alu_write_s = 1'b1; end
          FN_AND:  begin alu_op_s = ALU_AND;  alu_write_s = 1'b1; end
          FN_OR:   begin alu_op_s = ALU_OR;   alu_write_s = 1'b1; end
          FN_XOR:  begin alu_op_s = ALU_XOR;  alu_write_s = 1'b1; end
          FN_NOR:  begin alu_op_s = ALU_NOR;  alu_write_s = 1'b1; end
          FN_SLT:  begin alu_op_s = ALU_SLT;  alu_write_s = 1'b1; end
          FN_SLTU: begin alu_op_s = ALU_SLTU; alu_write_s = 1'b1; end
          default: begin alu_write_s = 1'b0; end
        endcase
      end
      OP_J:   begin is_j_s = 1'b1; end
      OP_JAL: begin
        is_jal_s        = 1'b1;
        reg_w_sel_s     = 2'b10;
        w_mem_reg_sel_s = 2'b10;
      end
      OP_BEQ: begin is_beq_s = 1'b1; alu_op_s = ALU_SUB; imm_ext_sel_s = 1'b1; end
      OP_BNE: begin is_bne_s = 1'b1; alu_op_s = ALU_SUB; imm_ext_sel_s = 1'b1; end
      OP_ADDI: begin
        alu_op_s = ALU_ADD; portb_sel_s = 2'b10; imm_ext_sel_s = 1'b1;
        reg_w_sel_s = 2'b01; alu_write_s = 1'b1; can_trap_s = 1'b1;
      end
      OP_ADDIU: begin
        alu_op_s = ALU_ADD; portb_sel_s = 2'b10; imm_ext_sel_s = 1'b1;
        reg_w_sel_s = 2'b01; alu_write_s = 1'b1;
      end
      OP_SLTI: begin
        alu_op_s = ALU_SLT; portb_sel_s = 2'b10; imm_ext_sel_s = 1'b1;
        reg_w_sel_s = 2'b01; alu_write_s = 1'b1;
      end
      OP_SLTIU: begin
        alu_op_s = ALU_SLTU; portb_sel_s = 2'b10; imm_ext_sel_s = 1'b1;
        reg_w_sel_s = 2'b01; alu_write_s = 1'b1;
      end
      OP_ANDI: begin
        alu_op_s = ALU_AND; portb_sel_s = 2'b10; reg_w_sel_s = 2'b01; alu_write_s = 1'b1;
      end
      OP_ORI: begin
        alu_op_s = ALU_OR; portb_sel_s = 2'b10; reg_w_sel_s = 2'b01; alu_write_s = 1'b1;
      end
      OP_XORI: begin
        alu_op_s = ALU_XOR; portb_sel_s = 2'b10; reg_w_sel_s = 2'b01; alu_write_s = 1'b1;
      end
      OP_LUI: begin
        // imm on port A shifted left by the constant 16 on port B
        alu_op_s = ALU_SLL; porta_sel_s = 1'b1; portb_sel_s = 2'b11;
        reg_w_sel_s = 2'b01; alu_write_s = 1'b1;
      end
      OP_LW: begin
        is_lw_s = 1'b1; alu_op_s = ALU_ADD; portb_sel_s = 2'b10; imm_ext_sel_s = 1'b1;
        reg_w_sel_s = 2'b01; w_mem_reg_sel_s = 2'b01; alu_write_s = 1'b1;
      end
      OP_SW: begin
        is_sw_s = 1'b1; alu_op_s = ALU_ADD; portb_sel_s = 2'b10; imm_ext_sel_s = 1'b1;
      end
      OP_HALT: begin is_halt_s = 1'b1; end
      default: begin alu_write_s = 1'b0; end
    endcase
  end

  // Next-PC select, with the branch outcome taken from the ALU zero flag
  always_comb begin
    if (is_j_s || is_jal_s) begin
      pc_sel_s = 2'b10;
    end else if (is_jr_s) begin
      pc_sel_s = 2'b01;
    end else if ((is_beq_s && zero) || (is_bne_s && !zero)) begin
      pc_sel_s = 2'b11;
    end else begin
      pc_sel_s = 2'b00;
    end
  end

  assign timeout_s = (MEM_TIMEOUT != 0) && (wait_cnt_r == TIMEOUT_V);

  // Sequencer: next state, strobes and retire pulse from state + IR + handshakes
  always_comb begin
    next_state_s = state_r;
    i_ren_s      = 1'b0;
    ir_wen_s     = 1'b0;
    d_ren_s      = 1'b0;
    d_wen_s      = 1'b0;
    reg_wen_s    = 1'b0;
    pc_wen_s     = 1'b0;
    retire_s     = 1'b0;
    case (state_r)
      ST_FETCH: begin
        i_ren_s = 1'b1;
        if (ihit) begin
          ir_wen_s     = 1'b1;
          next_state_s = ST_DECODE;
        end else if (timeout_s) begin
          next_state_s = ST_ERROR;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (is_halt_s) begin
          next_state_s = ST_HALTED;
        end else begin
          next_state_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_j_s || is_jr_s || is_beq_s || is_bne_s) begin
          pc_wen_s     = 1'b1;
          retire_s     = 1'b1;
          next_state_s = ST_FETCH;
        end else if (is_lw_s || is_sw_s) begin
          next_state_s = ST_MEM;
        end else if (can_trap_s && of) begin
          next_state_s = ST_HALTED;
        end else begin
          next_state_s = ST_WB;
        end
      end
      ST_MEM: begin
        d_ren_s = is_lw_s;
        d_wen_s = is_sw_s;
        if (dhit) begin
          if (is_sw_s) begin
            pc_wen_s     = 1'b1;
            retire_s     = 1'b1;
            next_state_s = ST_FETCH;
          end else begin
            next_state_s = ST_WB;
          end
        end else if (timeout_s) begin
          next_state_s = ST_ERROR;
        end else begin
          next_state_s = ST_MEM;
        end
      end
      ST_WB: begin
        // Unknown encodings arrive here too and retire without writing
        reg_wen_s    = alu_write_s || is_jal_s;
        pc_wen_s     = 1'b1;
        retire_s     = 1'b1;
        next_state_s = ST_FETCH;
      end
      ST_HALTED: begin
        next_state_s = ST_HALTED;
      end
      ST_ERROR: begin
        next_state_s = ST_ERROR;
      end
      default: begin
        next_state_s = ST_ERROR;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Memory wait counter: cleared on every state change, counts miss cycles
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wait_cnt_r <= '0;
    end else if (next_state_s != state_r) begin
      wait_cnt_r <= '0;
    end else if (((state_r == ST_FETCH) || (state_r == ST_MEM)) && (wait_cnt_r != '1)) begin
      wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Sticky halt / error flags, set together with the trap state
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      halt_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      halt_r <= halt_r || (next_state_s == ST_HALTED) || (next_state_s == ST_ERROR);
      err_r  <= err_r  || (next_state_s == ST_ERROR);
    end
  end

  // Saturating retired-instruction counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      retire_cnt_r <= '0;
    end else if (retire_s && (retire_cnt_r != '1)) begin
      retire_cnt_r <= retire_cnt_r + CNT_W'(1);
    end else begin
      retire_cnt_r <= retire_cnt_r;
    end
  end

  assign iREN        = i_ren_s;
  assign irWEN       = ir_wen_s;
  assign dREN        = d_ren_s;
  assign dWEN        = d_wen_s;
  assign regWEN      = reg_wen_s;
  assign pcWEN       = pc_wen_s;
  assign aluOp       = alu_op_s;
  assign portb_sel   = portb_sel_s;
  assign porta_sel   = porta_sel_s;
  assign immExt_sel  = imm_ext_sel_s;
  assign regW_sel    = reg_w_sel_s;
  assign wMemReg_sel = w_mem_reg_sel_s;
  assign pc_sel      = pc_sel_s;
  assign halt        = halt_r;
  assign err         = err_r;
  assign retire_cnt  = retire_cnt_r;

endmodule
